data_memory_sized: RTL and testbench

Byte-addressable, little-endian data memory for the pipelined CPU's MEM stage. Supports byte, halfword and word loads and stores, with sign or zero extension on loads. Reads are registered with a one-cycle latency, and misaligned or out-of-range accesses are flagged. After every reset, a hardware clear sequence zeroes the whole array.

---
 rtl/data_mem_pkg.sv | 25 ++
 rtl/data_mem_align.sv | 57 +++++
 rtl/data_memory_sized.sv | 137 +++++++++++++
 tb/tb_data_memory_sized.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the byte-addressable data memory.
// Size codes, controller states and the access-size to byte-count mapping.
package data_mem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Reserved size reports zero bytes; callers reject it before using the count.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_align.sv
// Lane steering for stores and byte/half extraction with extension for loads.
// Purely combinational; assumes the access is already known to be aligned.
module data_mem_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be_o    = 4'b0000;
        wlane_o = 32'h0;
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wlane_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wlane_o = {2{wdata_i[15:0]}};
            end
            SZ_W: begin
                be_o    = 4'b1111;
                wlane_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wlane_o = 32'h0;
            end
        endcase
    end

    assign shifted = rword_i >> {addr_lo_i, 3'b000};
    assign rbyte   = shifted[7:0];
    assign rhalf   = shifted[15:0];

    always_comb begin
        rdata_o = 32'h0;
        case (size_i)
            SZ_B:    rdata_o = {{24{rbyte[7] & ~unsigned_i}}, rbyte};
            SZ_H:    rdata_o = {{16{rhalf[15] & ~unsigned_i}}, rhalf};
            SZ_W:    rdata_o = rword_i;
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressable little-endian data memory with registered loads, legality
// checking, and a word-per-cycle hardware clear after every reset.
module data_memory_sized
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 128,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    output logic [31:0]       data_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned PTR_W = IDX_W - 2;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WORDS - 1);
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);

    logic [7:0]  mem_q [DEPTH_BYTES];
    logic [31:0] word_view [WORDS];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              wr_en;

    logic [PTR_W-1:0]  widx;
    logic [2:0]        last_off;
    logic [ADDR_W:0]   end_addr;
    logic              misaligned, in_range, legal;
    logic [3:0]        be;
    logic [31:0]       wlane, rdata;

    for (genvar w = 0; w < WORDS; w++) begin : g_view
        assign word_view[w] = {mem_q[4*w+3], mem_q[4*w+2], mem_q[4*w+1], mem_q[4*w]};
    end

    assign widx = addr_i[IDX_W-1:2];

    // One extra bit keeps the end-of-access sum from wrapping back into range.
    assign last_off   = size_bytes(size_i) - 3'd1;
    assign end_addr   = {1'b0, addr_i} + {{(ADDR_W - 2){1'b0}}, last_off};
    assign in_range   = end_addr < DEPTH_EXT;
    assign misaligned = ((size_i == SZ_H) && addr_i[0]) ||
                        ((size_i == SZ_W) && (addr_i[1:0] != 2'b00));
    assign legal      = (size_i != SZ_RSV) && !misaligned && in_range;

    data_mem_align u_align (
        .addr_lo_i  (addr_i[1:0]),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .wdata_i    (data_i),
        .rword_i    (word_view[widx]),
        .be_o       (be),
        .wlane_o    (wlane),
        .rdata_o    (rdata)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (ptr_q == PTR_LAST) begin
                state_d = READY;
            end
        end else if (MemRead_i && MemWrite_i) begin
            err_d  = 1'b1;
            data_d = 32'h0;
        end else if (MemRead_i || MemWrite_i) begin
            if (!legal) begin
                err_d  = 1'b1;
                data_d = 32'h0;
            end else if (MemRead_i) begin
                valid_d = 1'b1;
                data_d  = rdata;
            end else begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // The array itself is not reset; the clear sequence zeroes it word by word.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                for (int j = 0; j < 4; j++) begin
                    mem_q[{ptr_q, 2'(j)}] <= 8'h00;
                end
            end else if (wr_en) begin
                for (int j = 0; j < 4; j++) begin
                    if (be[j]) begin
                        mem_q[{widx, 2'(j)}] <= wlane[8*j +: 8];
                    end
                end
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q == CLEAR);

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: stimulus pushes expected load/error
// responses, a negedge monitor pops and compares whenever valid_o or err_o is set.
module tb_data_memory_sized;
    import data_mem_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        err_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    data_memory_sized #(
        .DEPTH_BYTES (128),
        .ADDR_W      (32)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_o || err_o) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output valid=%0b err=%0b data=%h required=none",
                         valid_o, err_o, data_o);
            end else begin
                e = exp_q.pop_front();
                if (err_o !== e.err || valid_o !== !e.err || data_o !== e.data) begin
                    failures++;
                    $display("FAIL response got err=%0b valid=%0b data=%h required err=%0b data=%h",
                             err_o, valid_o, data_o, e.err, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic idle();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drives one request for one edge; loads and rejected requests expect a response.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic uns, input logic exp_err,
                       input logic [31:0] exp_data);
        exp_t e;
        addr_i     = a;
        data_i     = d;
        size_i     = sz;
        unsigned_i = uns;
        MemRead_i  = rd;
        MemWrite_i = wr;
        if (exp_err || (rd && !wr)) begin
            e.err  = exp_err;
            e.data = exp_err ? 32'h0 : exp_data;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while (busy_o && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check(name, n, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i      = 1'b1;
        addr_i     = 32'h0;
        data_i     = 32'h0;
        size_i     = SZ_W;
        unsigned_i = 1'b0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_data", data_o, 32'h0);
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_err", {31'b0, err_o}, 32'h0);
        check("rst_busy", {31'b0, busy_o}, 32'h1);
        rst_i = 1'b0;
        wait_clear("clear_len_first");

        // Garbage, then a one-cycle reset pulse must wipe it.
        req(1'b0, 1'b1, 32'h00, 32'hDEADBEEF, SZ_W, 1'b0, 1'b0, 32'h0);
        req(1'b0, 1'b1, 32'h14, 32'h5A5A5A5A, SZ_W, 1'b0, 1'b0, 32'h0);
        req(1'b0, 1'b1, 32'h7C, 32'hFFFFFFFF, SZ_W, 1'b0, 1'b0, 32'h0);
        check("garbage_written", dut.word_view[5], 32'h5A5A5A5A);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        wait_clear("clear_len_pulse");
        for (int i = 0; i < 32; i++) begin
            check($sformatf("cleared_word%0d", i), dut.word_view[i], 32'h0);
        end

        // Mixed stores and signed/unsigned loads.
        req(1'b0, 1'b1, 32'h10, 32'h8899AABB, SZ_W, 1'b0, 1'b0, 32'h0);
        req(1'b0, 1'b1, 32'h11, 32'h1234567F, SZ_B, 1'b0, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 1'b0, 32'h88997FBB);
        req(1'b1, 1'b0, 32'h13, 32'h0, SZ_B, 1'b0, 1'b0, 32'hFFFFFF88);
        req(1'b1, 1'b0, 32'h13, 32'h0, SZ_B, 1'b1, 1'b0, 32'h00000088);
        req(1'b1, 1'b0, 32'h11, 32'h0, SZ_B, 1'b0, 1'b0, 32'h0000007F);

        // Halfword store preserves the other half of the word.
        req(1'b0, 1'b1, 32'h20, 32'h11223344, SZ_W, 1'b0, 1'b0, 32'h0);
        req(1'b0, 1'b1, 32'h22, 32'hABCDF00D, SZ_H, 1'b0, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h22, 32'h0, SZ_H, 1'b1, 1'b0, 32'h0000F00D);
        req(1'b1, 1'b0, 32'h22, 32'h0, SZ_H, 1'b0, 1'b0, 32'hFFFFF00D);
        req(1'b1, 1'b0, 32'h20, 32'h0, SZ_H, 1'b0, 1'b0, 32'h00003344);
        req(1'b1, 1'b0, 32'h20, 32'h0, SZ_W, 1'b0, 1'b0, 32'hF00D3344);

        // Rejected requests: misaligned, out of range, reserved size.
        req(1'b1, 1'b0, 32'h06, 32'h0, SZ_W, 1'b0, 1'b1, 32'h0);
        req(1'b0, 1'b1, 32'h41, 32'hFFFFFFFF, SZ_H, 1'b0, 1'b1, 32'h0);
        req(1'b0, 1'b1, 32'h7E, 32'hFFFFFFFF, SZ_W, 1'b0, 1'b1, 32'h0);
        req(1'b1, 1'b0, 32'h00, 32'h0, SZ_RSV, 1'b0, 1'b1, 32'h0);
        req(1'b1, 1'b0, 32'h80, 32'h0, SZ_W, 1'b0, 1'b1, 32'h0);
        req(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, SZ_B, 1'b0, 1'b1, 32'h0);
        req(1'b0, 1'b1, 32'h7F, 32'hFFFFFFFF, SZ_H, 1'b0, 1'b1, 32'h0);
        check("no_write_0x40", dut.word_view[16], 32'h0);
        check("no_write_0x7C", dut.word_view[31], 32'h0);

        // Both strobes together are rejected and must not write.
        req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, SZ_W, 1'b0, 1'b1, 32'h0);
        check("no_write_both", dut.word_view[4], 32'h88997FBB);

        // Last word is legal; then four back-to-back loads.
        req(1'b0, 1'b1, 32'h7C, 32'hCAFEF00D, SZ_W, 1'b0, 1'b0, 32'h0);
        req(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, 1'b0, 1'b0, 32'h88997FBB);
        req(1'b1, 1'b0, 32'h20, 32'h0, SZ_W, 1'b0, 1'b0, 32'hF00D3344);
        req(1'b1, 1'b0, 32'h00, 32'h0, SZ_W, 1'b0, 1'b0, 32'h00000000);
        req(1'b1, 1'b0, 32'h7C, 32'h0, SZ_W, 1'b0, 1'b0, 32'hCAFEF00D);
        idle();
        check("hold_data", data_o, 32'hCAFEF00D);
        check("hold_valid", {31'b0, valid_o}, 32'h0);

        // Reset lands on the same edge a load is sampled.
        rst_i      = 1'b1;
        addr_i     = 32'h10;
        size_i     = SZ_W;
        MemRead_i  = 1'b1;
        MemWrite_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_data", data_o, 32'h0);
        check("midrst_valid", {31'b0, valid_o}, 32'h0);
        check("midrst_busy", {31'b0, busy_o}, 32'h1);
        // Requests held through the clear must be ignored entirely.
        rst_i      = 1'b0;
        MemWrite_i = 1'b1;
        wait_clear("clear_len_midrst");
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        check("midrst_cleared", dut.word_view[4], 32'h0);
        req(1'b1, 1'b0, 32'h7C, 32'h0, SZ_W, 1'b0, 1'b0, 32'h00000000);
        idle();
        idle();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
